sum_accumulator: RTL and testbench

SUM_ACCUMULATOR -- requirements
Module: sum_accumulator

---
 rtl/sum_accumulator.sv | 121 ++++++++++++
 tb/tb_sum_accumulator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// sum_accumulator: accepts a start request with a beat count, adds that many
// unsigned K-bit operands into an accumulator, then holds the sum plus a
// sticky carry-out flag until the consumer takes it.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The input side uses in_valid/in_ready and the output side uses
// out_valid/out_ready. A producer holding valid must keep its data stable
// until the transfer. Ready may depend on state only, never on valid.
//
// Optional feature: define ACC_SATURATE_EN to clamp the accumulator to
// all-ones on carry-out. Leave it undefined to wrap modulo 2^K. In both
// builds, the ovf flag records the carry.
module sum_accumulator #(
    parameter int K     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    input  logic             in_valid,
    input  logic [K-1:0]     in_data,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     out_sum,
    output logic             out_ovf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [K-1:0]     acc;
    logic             ovf;
    logic [CNT_W-1:0] cnt;
    logic [K:0]       sum_ext;
    logic             beat;

    // A beat is one accepted operand. sum_ext keeps the carry in bit K.
    assign beat    = in_valid && in_ready;
    assign sum_ext = {1'b0, acc} + {1'b0, in_data};

    // The result registers are always visible, including while idle.
    assign out_sum = acc;
    assign out_ovf = ovf;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. start is honoured only in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (beat && (cnt == CNT_W'(1))) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Output decode. All outputs depend on state only.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE:    busy      = 1'b0;
            ACCUM:   in_ready  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: busy      = 1'b0;
        endcase
    end

    // Datapath. Clear acc and ovf on start, then add one operand per beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= '0;
        end else if ((state == IDLE) && start) begin
            acc <= '0;
            ovf <= 1'b0;
            cnt <= len;
        end else if (beat) begin
            cnt <= cnt - CNT_W'(1);
            ovf <= ovf | sum_ext[K];
`ifdef ACC_SATURATE_EN
            // Once clamped, acc stays all-ones: any further non-zero add
            // carries again and re-clamps, and adding zero leaves it there.
            acc <= sum_ext[K] ? {K{1'b1}} : sum_ext[K-1:0];
`else
            acc <= sum_ext[K-1:0];
`endif
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// tb_sum_accumulator: directed, table-driven bench for sum_accumulator
// (K=8, CNT_W=4). It also runs hand-written sequences for the zero-length,
// back-pressure and mid-run reset cases.
module tb_sum_accumulator;

    localparam int K     = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic [K-1:0]     in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [K-1:0]     out_sum;
    logic             out_ovf;
    logic             busy;

    int total = 0;
    int bad   = 0;

    logic [K-1:0] exp_q[$];

    typedef struct {
        int              n;
        logic [3:0][7:0] beats;
        logic [7:0]      sum;
        logic            ovf;
    } vec_t;

    vec_t vecs[7];

    sum_accumulator #(.K(K), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf),
        .busy      (busy)
    );

    // Clock: 10 time-unit period. Inputs change and outputs are sampled on
    // the falling edge.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int n, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3,
                                input logic [7:0] s, input logic o);
        vec_t v;
        v.n     = n;
        v.beats = {b3, b2, b1, b0};
        v.sum   = s;
        v.ovf   = o;
        return v;
    endfunction

    // Pulse start for one cycle. On return the DUT has taken the start edge.
    task automatic do_start(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = CNT_W'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic check_result(input string tag, input logic ovf_exp);
        logic [7:0] e;
        e = exp_q.pop_front();
        check({tag, "_out_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_in_ready"},  32'(in_ready),  32'd0);
        check({tag, "_sum"},       32'(out_sum),   32'(e));
        check({tag, "_ovf"},       32'(out_ovf),   32'(ovf_exp));
    endtask

    task automatic drain(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_busy"},  32'(busy),      32'd0);
    endtask

    initial begin
`ifdef ACC_SATURATE_EN
        vecs[0] = mk(3,  10,  20,  30, 0,  60, 1'b0);
        vecs[1] = mk(3, 100, 100, 100, 0, 255, 1'b1);
        vecs[2] = mk(1, 255,   0,   0, 0, 255, 1'b0);
        vecs[3] = mk(2, 255,   1,   0, 0, 255, 1'b1);
        vecs[4] = mk(4,   1,   2,   3, 4,  10, 1'b0);
        vecs[5] = mk(4, 200, 100,   0, 5, 255, 1'b1);
        vecs[6] = mk(2, 128, 128,   0, 0, 255, 1'b1);
`else
        vecs[0] = mk(3,  10,  20,  30, 0,  60, 1'b0);
        vecs[1] = mk(3, 100, 100, 100, 0,  44, 1'b1);
        vecs[2] = mk(1, 255,   0,   0, 0, 255, 1'b0);
        vecs[3] = mk(2, 255,   1,   0, 0,   0, 1'b1);
        vecs[4] = mk(4,   1,   2,   3, 4,  10, 1'b0);
        vecs[5] = mk(4, 200, 100,   0, 5,  49, 1'b1);
        vecs[6] = mk(2, 128, 128,   0, 0,   0, 1'b1);
`endif

        // Reset block
        rst_n     = 1'b0;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_sum",   32'(out_sum),   32'd0);
        check("rst_out_ovf",   32'(out_ovf),   32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven accumulations with back-to-back beats
        for (int v = 0; v < 7; v++) begin
            exp_q.push_back(vecs[v].sum);
            do_start(vecs[v].n);
            check($sformatf("v%0d_accum_ready", v), 32'(in_ready), 32'd1);
            check($sformatf("v%0d_accum_busy", v),  32'(busy),     32'd1);
            for (int b = 0; b < vecs[v].n; b++) begin
                check($sformatf("v%0d_b%0d_no_early_valid", v, b), 32'(out_valid), 32'd0);
                send_beat(vecs[v].beats[b]);
            end
            check_result($sformatf("v%0d", v), vecs[v].ovf);
            drain($sformatf("v%0d", v));
        end

        // Zero length: go straight to DONE, clear the previous result, and
        // never raise in_ready.
        exp_q.push_back(8'd0);
        do_start(0);
        check_result("len0", 1'b0);
        drain("len0");
        check("len0_no_ready_after", 32'(in_ready), 32'd0);

        // Input gaps, start pulses ignored, and back-pressure on the result
        exp_q.push_back(8'd12);
        do_start(2);
        send_beat(8'd5);
        start = 1'b1;
        len   = 4'd3;
        @(negedge clk);
        start = 1'b0;
        check("gap_ready_held", 32'(in_ready), 32'd1);
        check("gap_sum_held",   32'(out_sum),  32'd5);
        @(negedge clk);
        send_beat(8'd7);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", c),   32'(out_sum),   32'd12);
            check($sformatf("bp%0d_ovf", c),   32'(out_ovf),   32'd0);
            start = (c % 2 == 0);
            len   = 4'd1;
            @(negedge clk);
        end
        start = 1'b0;
        check_result("bp", 1'b0);

        // A start in the same cycle as the output handshake is ignored.
        start     = 1'b1;
        len       = 4'd2;
        out_ready = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        out_ready = 1'b0;
        check("drain_start_busy",  32'(busy),     32'd0);
        check("drain_start_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        check("drain_start_still_idle", 32'(busy), 32'd0);

        // Reset in the middle of an accumulation
        do_start(4);
        send_beat(8'd3);
        send_beat(8'd4);
        check("pre_rst_sum", 32'(out_sum), 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy",      32'(busy),      32'd0);
        check("mid_rst_in_ready",  32'(in_ready),  32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_sum",       32'(out_sum),   32'd0);
        check("mid_rst_ovf",       32'(out_ovf),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_no_valid", 32'(out_valid), 32'd0);
        exp_q.push_back(8'd9);
        do_start(1);
        send_beat(8'd9);
        check_result("post_rst", 1'b0);
        drain("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net in case the main sequence stalls.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
